// File: rtl/multi_priority_encoder.sv
// Sequential multi-index priority encoder: accepts a request vector and reports set bits
// highest first, one index per output beat. Define MPE_COUNT_EN to add the out_remaining output.
module multi_priority_encoder #(
  parameter int WIDTH   = 12,
  parameter int MAX_OUT = 2,
  parameter int IDXW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
`ifdef MPE_COUNT_EN
  ,
  output logic [IDXW-1:0]  out_remaining
`endif
);

  localparam int CW  = $clog2(WIDTH + 2);
  localparam int CAP = (MAX_OUT == 0 || MAX_OUT > WIDTH) ? WIDTH : MAX_OUT;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] rem, rem_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic [IDXW-1:0]  scan_idx;
  logic             last_raw;

  function automatic logic [IDXW-1:0] top_idx(input logic [WIDTH-1:0] v);
    top_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) top_idx = IDXW'(i + 1);
    end
  endfunction

  function automatic logic [WIDTH-1:0] clear_top(input logic [WIDTH-1:0] v);
    logic hit;
    hit       = 1'b0;
    clear_top = v;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i] && !hit) begin
        clear_top[i] = 1'b0;
        hit          = 1'b1;
      end
    end
  endfunction

  assign scan_idx = top_idx(rem);

`ifdef MPE_COUNT_EN
  int pop_cnt;
  int left_cnt;
  int rem_cnt;

  function automatic int popcount(input logic [WIDTH-1:0] v);
    popcount = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) popcount = popcount + 1;
    end
  endfunction

  // Beats still owed: set bits left, capped by the per-vector beat budget.
  always_comb begin
    pop_cnt  = popcount(rem);
    left_cnt = (MAX_OUT == 0) ? WIDTH : (MAX_OUT - int'(count));
    rem_cnt  = (pop_cnt < left_cnt) ? pop_cnt : left_cnt;
  end

  assign last_raw      = (rem_cnt <= 1);
  assign out_remaining = (state == SCAN) ? IDXW'(rem_cnt) : '0;
`else
  assign last_raw = (rem == '0) || $onehot(rem) ||
                    ((MAX_OUT != 0) && (int'(count) == MAX_OUT - 1));
`endif

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    count_nxt = count;
    case (state)
      IDLE: begin
        if (in_valid) begin
          rem_nxt   = in_vec;
          count_nxt = '0;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (out_ready) begin
          rem_nxt = clear_top(rem);
          if (int'(count) < CAP) count_nxt = count + CW'(1);
          if (last_raw) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rem   <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      count <= count_nxt;
    end
  end

  // Outputs depend only on registered state, so a stalled beat stays stable.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == SCAN);
  assign out_idx   = (state == SCAN) ? scan_idx : '0;
  assign out_last  = (state == SCAN) && last_raw;

endmodule

// File: tb/tb_multi_priority_encoder.sv
// Directed bench for multi_priority_encoder: one instance with MAX_OUT=2, one with MAX_OUT=0.
module tb_multi_priority_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] in_vec = '0;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic        ordy_a = 1'b1, ordy_b = 1'b1;
  logic        irdy_a, irdy_b, ovld_a, ovld_b, last_a, last_b;
  logic [3:0]  idx_a, idx_b;
`ifdef MPE_COUNT_EN
  logic [3:0]  remn_a, remn_b;
`endif

  int total = 0;
  int bad   = 0;
  bit sel_b = 1'b0;

  always #5 clk = ~clk;

  multi_priority_encoder #(.WIDTH(12), .MAX_OUT(2)) u_a (
    .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(valid_a), .in_ready(irdy_a),
    .out_idx(idx_a), .out_valid(ovld_a), .out_ready(ordy_a), .out_last(last_a)
`ifdef MPE_COUNT_EN
    , .out_remaining(remn_a)
`endif
  );

  multi_priority_encoder #(.WIDTH(12), .MAX_OUT(0)) u_b (
    .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(valid_b), .in_ready(irdy_b),
    .out_idx(idx_b), .out_valid(ovld_b), .out_ready(ordy_b), .out_last(last_b)
`ifdef MPE_COUNT_EN
    , .out_remaining(remn_b)
`endif
  );

  wire       s_irdy = sel_b ? irdy_b : irdy_a;
  wire       s_ovld = sel_b ? ovld_b : ovld_a;
  wire       s_last = sel_b ? last_b : last_a;
  wire [3:0] s_idx  = sel_b ? idx_b  : idx_a;
`ifdef MPE_COUNT_EN
  wire [3:0] s_remn = sel_b ? remn_b : remn_a;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_in_ready"}, 32'(s_irdy), 1);
    chk({tag, "_out_valid"}, 32'(s_ovld), 0);
    chk({tag, "_out_idx"}, 32'(s_idx), 0);
    chk({tag, "_out_last"}, 32'(s_last), 0);
  endtask

  task automatic accept(input logic [11:0] v, input string tag);
    in_vec = v;
    if (sel_b) valid_b = 1'b1; else valid_a = 1'b1;
    chk({tag, "_ready_before"}, 32'(s_irdy), 1);
    tick();
    valid_a = 1'b0;
    valid_b = 1'b0;
    chk({tag, "_ready_busy"}, 32'(s_irdy), 0);
  endtask

  task automatic beat(input logic [3:0] idx, input bit last, input string tag);
    chk({tag, "_valid"}, 32'(s_ovld), 1);
    chk({tag, "_idx"}, 32'(s_idx), 32'(idx));
    chk({tag, "_last"}, 32'(s_last), 32'(last));
    tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state, sampled while rst is held
    #2;
    sel_b = 1'b0;
    chk("rst_a_valid", 32'(ovld_a), 0);
    chk("rst_a_idx", 32'(idx_a), 0);
    chk("rst_a_last", 32'(last_a), 0);
    chk("rst_b_valid", 32'(ovld_b), 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    idle_chk("post_rst_a");
    sel_b = 1'b1;
    idle_chk("post_rst_b");
`ifdef MPE_COUNT_EN
    chk("rst_remaining", 32'(remn_b), 0);
`endif

    // A05 with MAX_OUT=2: 12, 10(last)
    sel_b = 1'b0;
    accept(12'hA05, "a05_m2");
`ifdef MPE_COUNT_EN
    chk("a05_m2_rem0", 32'(s_remn), 2);
`endif
    beat(4'd12, 1'b0, "a05_m2_b0");
`ifdef MPE_COUNT_EN
    chk("a05_m2_rem1", 32'(s_remn), 1);
`endif
    beat(4'd10, 1'b1, "a05_m2_b1");
    idle_chk("a05_m2_done");

    // A05 with MAX_OUT=0: 12, 10, 3, 1(last)
    sel_b = 1'b1;
    accept(12'hA05, "a05_m0");
    beat(4'd12, 1'b0, "a05_m0_b0");
    beat(4'd10, 1'b0, "a05_m0_b1");
    beat(4'd3, 1'b0, "a05_m0_b2");
    beat(4'd1, 1'b1, "a05_m0_b3");
    idle_chk("a05_m0_done");

    // empty and lowest-bit vectors
    sel_b = 1'b0;
    accept(12'h000, "empty");
`ifdef MPE_COUNT_EN
    chk("empty_rem", 32'(s_remn), 0);
`endif
    beat(4'd0, 1'b1, "empty_b0");
    idle_chk("empty_done");
    accept(12'h001, "bit0");
    beat(4'd1, 1'b1, "bit0_b0");
    idle_chk("bit0_done");

    // popcount equal to MAX_OUT, and MAX_OUT cutting a full vector short
    accept(12'h030, "x030");
    beat(4'd6, 1'b0, "x030_b0");
    beat(4'd5, 1'b1, "x030_b1");
    accept(12'hFFF, "fff_m2");
    beat(4'd12, 1'b0, "fff_m2_b0");
    beat(4'd11, 1'b1, "fff_m2_b1");
    idle_chk("fff_m2_done");

    // stall on first beat of 840 while in_vec/in_valid wiggle
    sel_b  = 1'b1;
    ordy_b = 1'b0;
    accept(12'h840, "stall");
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 32'(s_ovld), 1);
      chk("stall_idx", 32'(s_idx), 12);
      chk("stall_last", 32'(s_last), 0);
      chk("stall_in_ready", 32'(s_irdy), 0);
      in_vec  = 12'h3FF ^ 12'(i);
      valid_b = 1'b1;
      tick();
    end
    valid_b = 1'b0;
    ordy_b  = 1'b1;
    beat(4'd12, 1'b0, "stall_b0");
    beat(4'd7, 1'b1, "stall_b1");
    idle_chk("stall_done");

    // asynchronous reset during the second beat of FFF
    accept(12'hFFF, "rstmid");
    beat(4'd12, 1'b0, "rstmid_b0");
    chk("rstmid_pre_idx", 32'(s_idx), 11);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_valid", 32'(s_ovld), 0);
    chk("rstmid_idx", 32'(s_idx), 0);
    chk("rstmid_last", 32'(s_last), 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    idle_chk("rstmid_rel");
    tick();
    idle_chk("rstmid_nostale");
    accept(12'h010, "x010");
    beat(4'd5, 1'b1, "x010_b0");
    idle_chk("x010_done");

    // 0F0 unlimited: 8, 7, 6, 5
    accept(12'h0F0, "x0f0");
    for (int i = 0; i < 4; i++) begin
`ifdef MPE_COUNT_EN
      chk("x0f0_rem", 32'(s_remn), 32'(4 - i));
`endif
      beat(4'(8 - i), (i == 3), "x0f0_b");
    end
    idle_chk("x0f0_done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
